// File: rtl/jedro_1_regfile_2r1w.sv
// rtl/jedro_1_regfile_2r1w.sv - jedro_1 integer register file, two read ports and one write port
//
// Purpose:
//   Register file for the jedro_1 core. Decode reads rs1/rs2 through ports A
//   and B while writeback writes through the single write port. Register 0
//   has no storage and always reads as zero.
//
// Parameters:
//   DATA_WIDTH - register width in bits
//   ADDR_WIDTH - address width, NUM_REGISTERS = 2**ADDR_WIDTH
//   BYPASS     - 1: a same-cycle write to the read address is forwarded
//                0: a same-cycle read returns the pre-write contents
//
// Ports:
//   clk_i       in   clock, rising edge
//   rstn_i      in   asynchronous active-low reset
//   rpa_re_i    in   port A read enable (0 holds rpa_data_o)
//   rpa_addr_i  in   port A read address
//   rpa_data_o  out  port A registered read data
//   rpb_re_i    in   port B read enable (0 holds rpb_data_o)
//   rpb_addr_i  in   port B read address
//   rpb_data_o  out  port B registered read data
//   wr_we_i     in   write enable
//   wr_addr_i   in   write address (writes to 0 are dropped)
//   wr_data_i   in   write data

module jedro_1_regfile_2r1w #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  rpa_re_i,
  input  logic [ADDR_WIDTH-1:0] rpa_addr_i,
  output logic [DATA_WIDTH-1:0] rpa_data_o,
  input  logic                  rpb_re_i,
  input  logic [ADDR_WIDTH-1:0] rpb_addr_i,
  output logic [DATA_WIDTH-1:0] rpb_data_o,
  input  logic                  wr_we_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i
);

  localparam int NUM_REGISTERS = 2 ** ADDR_WIDTH;

  // Storage exists only for registers 1..NUM_REGISTERS-1.
  logic [DATA_WIDTH-1:0] r_regs [1:NUM_REGISTERS-1];

  logic [DATA_WIDTH-1:0] r_rpa_data;
  logic [DATA_WIDTH-1:0] r_rpb_data;

  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_rpa_mem;
  logic [DATA_WIDTH-1:0] w_rpb_mem;
  logic                  w_rpa_byp;
  logic                  w_rpb_byp;
  logic [DATA_WIDTH-1:0] w_rpa_next;
  logic [DATA_WIDTH-1:0] w_rpb_next;

  // A write to x0 is a no-op; folding that in here also keeps x0 out of the
  // bypass path, so a read of x0 can never pick up forwarded data.
  assign w_wr_en = wr_we_i && (wr_addr_i != '0);

  // Read muxes. Address 0 matches no storage entry and falls through to the
  // zero default.
  always_comb begin
    w_rpa_mem = '0;
    w_rpb_mem = '0;
    for (int i = 1; i < NUM_REGISTERS; i++) begin
      if (rpa_addr_i == ADDR_WIDTH'(i)) begin
        w_rpa_mem = r_regs[i];
      end
      if (rpb_addr_i == ADDR_WIDTH'(i)) begin
        w_rpb_mem = r_regs[i];
      end
    end
  end

  always_comb begin
    w_rpa_byp = (BYPASS != 0) && w_wr_en && (wr_addr_i == rpa_addr_i);
    w_rpb_byp = (BYPASS != 0) && w_wr_en && (wr_addr_i == rpb_addr_i);
    w_rpa_next = w_rpa_byp ? wr_data_i : w_rpa_mem;
    w_rpb_next = w_rpb_byp ? wr_data_i : w_rpb_mem;
  end

  // Register storage.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 1; i < NUM_REGISTERS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGISTERS; i++) begin
        if (w_wr_en && (wr_addr_i == ADDR_WIDTH'(i))) begin
          r_regs[i] <= wr_data_i;
        end
      end
    end
  end

  // Read output registers; a deasserted enable holds the last value so a
  // stalled decode stage keeps its operands.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rpa_data <= '0;
      r_rpb_data <= '0;
    end else begin
      if (rpa_re_i) begin
        r_rpa_data <= w_rpa_next;
      end
      if (rpb_re_i) begin
        r_rpb_data <= w_rpb_next;
      end
    end
  end

  assign rpa_data_o = r_rpa_data;
  assign rpb_data_o = r_rpb_data;

endmodule

// File: tb/tb_jedro_1_regfile_2r1w.sv
// tb/tb_jedro_1_regfile_2r1w.sv - scoreboard bench for jedro_1_regfile_2r1w

module tb_jedro_1_regfile_2r1w;

  logic        clk;
  logic        rstn;
  logic        rpa_re;
  logic [4:0]  rpa_addr;
  logic        rpb_re;
  logic [4:0]  rpb_addr;
  logic        wr_we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] a1_data, b1_data, a0_data, b0_data;

  logic        s_rpa_re;
  logic [2:0]  s_rpa_addr;
  logic        s_rpb_re;
  logic [2:0]  s_rpb_addr;
  logic        s_wr_we;
  logic [2:0]  s_wr_addr;
  logic [15:0] s_wr_data;
  logic [15:0] s_a_data, s_b_data;

  int n_cmp;
  int n_bad;

  logic [31:0] mem [0:31];
  logic [31:0] last_a1, last_b1, last_a0, last_b0;
  logic [31:0] q_a1 [$];
  logic [31:0] q_b1 [$];
  logic [31:0] q_a0 [$];
  logic [31:0] q_b0 [$];

  logic [15:0] smem [0:7];
  logic [15:0] s_last_a, s_last_b;
  logic [15:0] q_sa [$];
  logic [15:0] q_sb [$];

  jedro_1_regfile_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) u_dut_byp (
    .clk_i(clk), .rstn_i(rstn),
    .rpa_re_i(rpa_re), .rpa_addr_i(rpa_addr), .rpa_data_o(a1_data),
    .rpb_re_i(rpb_re), .rpb_addr_i(rpb_addr), .rpb_data_o(b1_data),
    .wr_we_i(wr_we), .wr_addr_i(wr_addr), .wr_data_i(wr_data)
  );

  jedro_1_regfile_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) u_dut_nobyp (
    .clk_i(clk), .rstn_i(rstn),
    .rpa_re_i(rpa_re), .rpa_addr_i(rpa_addr), .rpa_data_o(a0_data),
    .rpb_re_i(rpb_re), .rpb_addr_i(rpb_addr), .rpb_data_o(b0_data),
    .wr_we_i(wr_we), .wr_addr_i(wr_addr), .wr_data_i(wr_data)
  );

  jedro_1_regfile_2r1w #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .BYPASS(1)) u_dut_small (
    .clk_i(clk), .rstn_i(rstn),
    .rpa_re_i(s_rpa_re), .rpa_addr_i(s_rpa_addr), .rpa_data_o(s_a_data),
    .rpb_re_i(s_rpb_re), .rpb_addr_i(s_rpb_addr), .rpb_data_o(s_b_data),
    .wr_we_i(s_wr_we), .wr_addr_i(s_wr_addr), .wr_data_i(s_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one cycle on the 32-bit pair, pushes the model's expectations,
  // then pops and compares after the edge. Called at a falling edge.
  task automatic cycle(input string tag,
                       input logic are, input logic [4:0] aa,
                       input logic bre, input logic [4:0] ba,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    logic [31:0] e;
    rpa_re = are; rpa_addr = aa;
    rpb_re = bre; rpb_addr = ba;
    wr_we = we; wr_addr = wa; wr_data = wd;
    if (are) begin
      e = (aa == 0) ? 32'h0 : mem[aa];
      last_a0 = e;
      last_a1 = (we && wa == aa && aa != 0) ? wd : e;
    end
    if (bre) begin
      e = (ba == 0) ? 32'h0 : mem[ba];
      last_b0 = e;
      last_b1 = (we && wa == ba && ba != 0) ? wd : e;
    end
    q_a1.push_back(last_a1);
    q_b1.push_back(last_b1);
    q_a0.push_back(last_a0);
    q_b0.push_back(last_b0);
    @(posedge clk);
    if (we && wa != 0) mem[wa] = wd;
    @(negedge clk);
    chk({tag, "/A/byp"},   a1_data, q_a1.pop_front());
    chk({tag, "/B/byp"},   b1_data, q_b1.pop_front());
    chk({tag, "/A/nobyp"}, a0_data, q_a0.pop_front());
    chk({tag, "/B/nobyp"}, b0_data, q_b0.pop_front());
  endtask

  task automatic scycle(input string tag,
                        input logic are, input logic [2:0] aa,
                        input logic bre, input logic [2:0] ba,
                        input logic we, input logic [2:0] wa, input logic [15:0] wd);
    s_rpa_re = are; s_rpa_addr = aa;
    s_rpb_re = bre; s_rpb_addr = ba;
    s_wr_we = we; s_wr_addr = wa; s_wr_data = wd;
    if (are) s_last_a = (aa == 0) ? 16'h0 : ((we && wa == aa) ? wd : smem[aa]);
    if (bre) s_last_b = (ba == 0) ? 16'h0 : ((we && wa == ba) ? wd : smem[ba]);
    q_sa.push_back(s_last_a);
    q_sb.push_back(s_last_b);
    @(posedge clk);
    if (we && wa != 0) smem[wa] = wd;
    @(negedge clk);
    chk({tag, "/A"}, {16'h0, s_a_data}, {16'h0, q_sa.pop_front()});
    chk({tag, "/B"}, {16'h0, s_b_data}, {16'h0, q_sb.pop_front()});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    for (int i = 0; i < 8; i++) smem[i] = '0;
    last_a1 = '0; last_b1 = '0; last_a0 = '0; last_b0 = '0;
    s_last_a = '0; s_last_b = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rstn = 1'b0;
    rpa_re = 0; rpa_addr = 0; rpb_re = 0; rpb_addr = 0;
    wr_we = 0; wr_addr = 0; wr_data = 0;
    s_rpa_re = 0; s_rpa_addr = 0; s_rpb_re = 0; s_rpb_addr = 0;
    s_wr_we = 0; s_wr_addr = 0; s_wr_data = 0;
    model_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst/A/byp", a1_data, 32'h0);
    chk("rst/B/byp", b1_data, 32'h0);
    chk("rst/small/A", {16'h0, s_a_data}, 32'h0);
    rstn = 1'b1;

    // Asynchronous reset in mid-operation
    cycle("pre5w", 0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    cycle("pre5r", 1, 5'd5, 1, 5'd5, 0, 0, 0);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst/A/byp",   a1_data, 32'h0);
    chk("arst/B/byp",   b1_data, 32'h0);
    chk("arst/A/nobyp", a0_data, 32'h0);
    chk("arst/B/nobyp", b0_data, 32'h0);
    wr_we = 1; wr_addr = 5'd5; wr_data = 32'h55555555;
    rpa_re = 1; rpa_addr = 5'd5;
    @(posedge clk);
    @(negedge clk);
    chk("inrst/A/byp", a1_data, 32'h0);
    model_reset();
    rstn = 1'b1;
    cycle("postrst5", 1, 5'd5, 1, 5'd5, 0, 0, 0);

    // Basic write/read
    cycle("w1",  0, 0, 0, 0, 1, 5'd1,  32'h11111111);
    cycle("w31", 0, 0, 0, 0, 1, 5'd31, 32'hFFFF0000);
    cycle("r1_31", 1, 5'd1, 1, 5'd31, 0, 0, 0);

    // x0
    cycle("x0wr", 1, 5'd0, 1, 5'd0, 1, 5'd0, 32'hCAFEBABE);
    cycle("x0rd", 1, 5'd0, 1, 5'd0, 0, 0, 0);

    // Bypass
    cycle("w7",    0, 0, 0, 0, 1, 5'd7, 32'h00000007);
    cycle("byp7",  1, 5'd7, 1, 5'd7, 1, 5'd7, 32'h000000AA);
    cycle("next7", 1, 5'd7, 1, 5'd7, 0, 0, 0);

    // Hold
    cycle("w2",    0, 0, 0, 0, 1, 5'd2, 32'h00002222);
    cycle("r2",    1, 5'd2, 0, 0, 0, 0, 0);
    cycle("hold0", 0, 5'd3, 0, 0, 1, 5'd2, 32'h00009999);
    cycle("hold1", 0, 5'd31, 0, 0, 0, 0, 0);
    cycle("hold2", 0, 5'd2, 0, 0, 0, 0, 0);
    cycle("r2new", 1, 5'd2, 0, 0, 0, 0, 0);

    // Random mix
    for (int k = 0; k < 40; k++) begin
      cycle("rnd", 1'($urandom), 5'($urandom_range(0, 7)),
                   1'($urandom), 5'($urandom_range(0, 7)),
                   1'($urandom), 5'($urandom_range(0, 7)), $urandom);
    end

    // Parameter sweep on the 16-bit / 8-entry instance
    for (int k = 0; k < 8; k++) begin
      scycle("sw", 0, 0, 0, 0, 1, 3'(k), 16'((k << 8) | k));
    end
    for (int k = 0; k < 8; k += 2) begin
      scycle("sr", 1, 3'(k), 1, 3'(k + 1), 0, 0, 0);
    end
    scycle("sr_swap", 1, 3'd7, 1, 3'd0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
